// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: bus bundle between cache_ctrl and its neighbours.
//   CPU side   : cpu_req/cpu_wr/cpu_addr/cpu_wdata in, cpu_rdata/cpu_done/cpu_busy out
//   Cache port : enable/ack access port; controller is the initiator
//   Memory port: req/ack word port to backing memory
//   err        : sticky timeout flag
// Modports: master = cache_ctrl view, slave = CPU/cache/memory view.
interface cache_ctrl_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [0:10] cpu_addr;
    logic [0:15] cpu_wdata;
    logic [0:15] cpu_rdata;
    logic        cpu_done;
    logic        cpu_busy;

    logic        cache_enable;
    logic [0:3]  cache_index;
    logic [0:1]  cache_word;
    logic        cache_comp;
    logic        cache_write;
    logic [0:4]  cache_tag_in;
    logic [0:15] cache_data_in;
    logic        cache_valid_in;
    logic        cache_hit;
    logic        cache_dirty;
    logic        cache_valid;
    logic [0:4]  cache_tag_out;
    logic [0:15] cache_data_out;
    logic        cache_ack;

    logic        mem_req;
    logic        mem_wr;
    logic [0:10] mem_addr;
    logic [0:15] mem_wdata;
    logic [0:15] mem_rdata;
    logic        mem_ack;

    logic        err;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_busy,
        output cache_enable, cache_index, cache_word, cache_comp, cache_write,
               cache_tag_in, cache_data_in, cache_valid_in,
        input  cache_hit, cache_dirty, cache_valid, cache_tag_out, cache_data_out, cache_ack,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output err
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_busy,
        input  cache_enable, cache_index, cache_word, cache_comp, cache_write,
               cache_tag_in, cache_data_in, cache_valid_in,
        output cache_hit, cache_dirty, cache_valid, cache_tag_out, cache_data_out, cache_ack,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  err
    );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: single-word CPU requests against a 16-line x 4-word cache.
// Compare access first; on a miss, write back a dirty victim line (4 words),
// fill the line from memory (4 words), then replay the compare access.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - cache_ctrl_if.master (CPU, cache and memory signals, err)
// Parameters: TIMEOUT (wait limit in cycles), TO_W (timeout counter width).
// Optional feature: define CACHE_CTRL_TIMEOUT_EN to bound every cache/memory
// wait; otherwise waits are unbounded and err is tied low.
module cache_ctrl #(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned TO_W    = 8
) (
    input logic          clk,
    input logic          rst,
    cache_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, COMP, WB_RD, WB_WR, FILL_RD, FILL_WR, RETRY, DONE
    } state_t;

    state_t      r_state;
    logic        r_rel;       // strobe dropped, waiting for the ack to go low
    logic [1:0]  r_w;
    logic        r_wr;
    logic [0:4]  r_tag;
    logic [0:3]  r_index;
    logic [0:1]  r_word;
    logic [0:15] r_wdata;
    logic [0:4]  r_victim;
    logic [0:15] r_data;
    logic        r_hit;
    logic        r_evict;

    logic        r_cache_enable, r_cache_comp, r_cache_write, r_cache_valid_in;
    logic [0:3]  r_cache_index;
    logic [0:1]  r_cache_word;
    logic [0:4]  r_cache_tag_in;
    logic [0:15] r_cache_data_in;
    logic        r_mem_req, r_mem_wr;
    logic [0:10] r_mem_addr;
    logic [0:15] r_mem_wdata;
    logic [0:15] r_cpu_rdata;
    logic        r_cpu_done, r_cpu_busy;

    logic [0:4]  w_req_tag;
    logic [0:3]  w_req_index;
    logic [0:1]  w_req_word;

    assign w_req_tag   = bus.cpu_addr[0:4];
    assign w_req_index = bus.cpu_addr[5:8];
    assign w_req_word  = bus.cpu_addr[9:10];

    assign bus.cache_enable   = r_cache_enable;
    assign bus.cache_index    = r_cache_index;
    assign bus.cache_word     = r_cache_word;
    assign bus.cache_comp     = r_cache_comp;
    assign bus.cache_write    = r_cache_write;
    assign bus.cache_tag_in   = r_cache_tag_in;
    assign bus.cache_data_in  = r_cache_data_in;
    assign bus.cache_valid_in = r_cache_valid_in;
    assign bus.mem_req        = r_mem_req;
    assign bus.mem_wr         = r_mem_wr;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.cpu_rdata      = r_cpu_rdata;
    assign bus.cpu_done       = r_cpu_done;
    assign bus.cpu_busy       = r_cpu_busy;

`ifdef CACHE_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_waiting;
    assign w_waiting = r_cache_enable || r_mem_req;
    assign bus.err   = r_err;
`else
    assign bus.err   = 1'b0;
`endif

    // Every access phase has two halves: strobe held until ack, then strobe
    // low until the ack is seen low, after which the next strobe may rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_rel            <= 1'b0;
            r_w              <= '0;
            r_wr             <= 1'b0;
            r_tag            <= '0;
            r_index          <= '0;
            r_word           <= '0;
            r_wdata          <= '0;
            r_victim         <= '0;
            r_data           <= '0;
            r_hit            <= 1'b0;
            r_evict          <= 1'b0;
            r_cache_enable   <= 1'b0;
            r_cache_comp     <= 1'b0;
            r_cache_write    <= 1'b0;
            r_cache_valid_in <= 1'b0;
            r_cache_index    <= '0;
            r_cache_word     <= '0;
            r_cache_tag_in   <= '0;
            r_cache_data_in  <= '0;
            r_mem_req        <= 1'b0;
            r_mem_wr         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_cpu_rdata      <= '0;
            r_cpu_done       <= 1'b0;
            r_cpu_busy       <= 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
            r_to_cnt         <= '0;
            r_err            <= 1'b0;
`endif
        end else begin
            r_cpu_done  <= 1'b0;
            r_cpu_rdata <= '0;
`ifdef CACHE_CTRL_TIMEOUT_EN
            r_to_cnt <= w_waiting ? r_to_cnt + 1'b1 : '0;
            if (w_waiting && (r_to_cnt == TO_W'(TIMEOUT - 1))) begin
                r_err          <= 1'b1;
                r_cache_enable <= 1'b0;
                r_mem_req      <= 1'b0;
                r_cpu_done     <= 1'b1;
                r_cpu_busy     <= 1'b0;
                r_rel          <= 1'b0;
                r_to_cnt       <= '0;
                r_state        <= IDLE;
            end else
`endif
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req && !bus.cache_ack) begin
                        r_tag            <= w_req_tag;
                        r_index          <= w_req_index;
                        r_word           <= w_req_word;
                        r_wr             <= bus.cpu_wr;
                        r_wdata          <= bus.cpu_wdata;
                        r_cpu_busy       <= 1'b1;
                        r_rel            <= 1'b0;
                        r_state          <= COMP;
                        r_cache_enable   <= 1'b1;
                        r_cache_comp     <= 1'b1;
                        r_cache_write    <= bus.cpu_wr;
                        r_cache_index    <= w_req_index;
                        r_cache_word     <= w_req_word;
                        r_cache_tag_in   <= w_req_tag;
                        r_cache_data_in  <= bus.cpu_wdata;
                        r_cache_valid_in <= 1'b0;
                    end
                end
                COMP, RETRY: begin
                    if (!r_rel) begin
                        if (bus.cache_ack) begin
                            r_cache_enable <= 1'b0;
                            r_rel          <= 1'b1;
                            // the replayed access follows a fresh fill, so it always counts as a hit
                            r_hit          <= bus.cache_hit || (r_state == RETRY);
                            r_evict        <= bus.cache_valid && bus.cache_dirty;
                            r_victim       <= bus.cache_tag_out;
                            r_data         <= bus.cache_data_out;
                        end
                    end else if (!bus.cache_ack) begin
                        r_rel <= 1'b0;
                        r_w   <= '0;
                        if (r_hit) begin
                            r_state     <= DONE;
                            r_cpu_done  <= 1'b1;
                            r_cpu_rdata <= r_wr ? '0 : r_data;
                        end else if (r_evict) begin
                            r_state          <= WB_RD;
                            r_cache_enable   <= 1'b1;
                            r_cache_comp     <= 1'b0;
                            r_cache_write    <= 1'b0;
                            r_cache_word     <= 2'd0;
                            r_cache_valid_in <= 1'b0;
                        end else begin
                            r_state    <= FILL_RD;
                            r_mem_req  <= 1'b1;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= {r_tag, r_index, 2'd0};
                        end
                    end
                end
                WB_RD: begin
                    if (!r_rel) begin
                        if (bus.cache_ack) begin
                            r_cache_enable <= 1'b0;
                            r_rel          <= 1'b1;
                            r_data         <= bus.cache_data_out;
                        end
                    end else if (!bus.cache_ack) begin
                        r_rel       <= 1'b0;
                        r_state     <= WB_WR;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= {r_victim, r_index, r_w};
                        r_mem_wdata <= r_data;
                    end
                end
                WB_WR: begin
                    if (!r_rel) begin
                        if (bus.mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_rel     <= 1'b1;
                        end
                    end else if (!bus.mem_ack) begin
                        r_rel <= 1'b0;
                        if (r_w == 2'd3) begin
                            r_w        <= '0;
                            r_state    <= FILL_RD;
                            r_mem_req  <= 1'b1;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= {r_tag, r_index, 2'd0};
                        end else begin
                            r_w            <= r_w + 2'd1;
                            r_state        <= WB_RD;
                            r_cache_enable <= 1'b1;
                            r_cache_word   <= r_w + 2'd1;
                        end
                    end
                end
                FILL_RD: begin
                    if (!r_rel) begin
                        if (bus.mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_rel     <= 1'b1;
                            r_data    <= bus.mem_rdata;
                        end
                    end else if (!bus.mem_ack) begin
                        r_rel            <= 1'b0;
                        r_state          <= FILL_WR;
                        r_cache_enable   <= 1'b1;
                        r_cache_comp     <= 1'b0;
                        r_cache_write    <= 1'b1;
                        r_cache_word     <= r_w;
                        r_cache_tag_in   <= r_tag;
                        r_cache_data_in  <= r_data;
                        r_cache_valid_in <= 1'b1;
                    end
                end
                FILL_WR: begin
                    if (!r_rel) begin
                        if (bus.cache_ack) begin
                            r_cache_enable <= 1'b0;
                            r_rel          <= 1'b1;
                        end
                    end else if (!bus.cache_ack) begin
                        r_rel <= 1'b0;
                        if (r_w == 2'd3) begin
                            r_w              <= '0;
                            r_state          <= RETRY;
                            r_cache_enable   <= 1'b1;
                            r_cache_comp     <= 1'b1;
                            r_cache_write    <= r_wr;
                            r_cache_word     <= r_word;
                            r_cache_tag_in   <= r_tag;
                            r_cache_data_in  <= r_wdata;
                            r_cache_valid_in <= 1'b0;
                        end else begin
                            r_w        <= r_w + 2'd1;
                            r_state    <= FILL_RD;
                            r_mem_req  <= 1'b1;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= {r_tag, r_index, r_w + 2'd1};
                        end
                    end
                end
                DONE: begin
                    r_cpu_busy <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a behavioural cache array
// and backing memory acting as responders.
module tb_cache_ctrl;

`ifdef CACHE_CTRL_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 10;
`else
    localparam int unsigned TB_TIMEOUT = 200;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_if bus();

    cache_ctrl #(.TIMEOUT(TB_TIMEOUT), .TO_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- cache array model ----------------
    logic        c_valid [16];
    logic        c_dirty [16];
    logic [0:4]  c_tag   [16];
    logic [0:15] c_data  [16][4];
    int          ack_delay = 0;
    int          ack_extra = 0;
    int          c_cnt = 0, c_hold = 0, ci, cw;
    logic        chit;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cache_ack <= 1'b0;
            c_cnt  <= 0;
            c_hold <= 0;
        end else if (bus.cache_ack) begin
            if (c_hold < ack_extra) c_hold <= c_hold + 1;
            else begin
                bus.cache_ack <= 1'b0;
                c_hold <= 0;
            end
        end else if (bus.cache_enable) begin
            if (c_cnt == ack_delay) begin
                c_cnt = 0;
                ci   = int'(bus.cache_index);
                cw   = int'(bus.cache_word);
                chit = c_valid[ci] && (c_tag[ci] == bus.cache_tag_in);
                bus.cache_ack      <= 1'b1;
                bus.cache_hit      <= bus.cache_comp && chit;
                bus.cache_valid    <= c_valid[ci];
                bus.cache_dirty    <= c_dirty[ci];
                bus.cache_tag_out  <= c_tag[ci];
                bus.cache_data_out <= c_data[ci][cw];
                if (bus.cache_write) begin
                    if (bus.cache_comp) begin
                        if (chit) begin
                            c_data[ci][cw] = bus.cache_data_in;
                            c_dirty[ci]    = 1'b1;
                        end
                    end else begin
                        c_data[ci][cw] = bus.cache_data_in;
                        c_tag[ci]      = bus.cache_tag_in;
                        c_valid[ci]    = bus.cache_valid_in;
                        c_dirty[ci]    = 1'b0;
                    end
                end
            end else c_cnt <= c_cnt + 1;
        end
    end

    // ---------------- memory model ----------------
    logic [0:15] mem [2048];
    logic        mem_ack_en = 1'b1;
    logic [0:10] mr_q[$];
    logic [0:10] mw_addr_q[$];
    logic [0:15] mw_data_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) bus.mem_ack <= 1'b0;
        else if (bus.mem_ack) bus.mem_ack <= 1'b0;
        else if (bus.mem_req && mem_ack_en) begin
            bus.mem_ack <= 1'b1;
            if (bus.mem_wr) begin
                mem[bus.mem_addr] = bus.mem_wdata;
                mw_addr_q.push_back(bus.mem_addr);
                mw_data_q.push_back(bus.mem_wdata);
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
                mr_q.push_back(bus.mem_addr);
            end
        end
    end

    // ---------------- handshake monitor ----------------
    logic [29:0] p_cf = '0;
    logic [27:0] p_mf = '0;
    logic        p_en = 1'b0, p_mreq = 1'b0, p_ack = 1'b0;
    int          viol_stable = 0, viol_reen = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.cache_enable && p_en && ({bus.cache_index, bus.cache_word, bus.cache_comp,
                bus.cache_write, bus.cache_tag_in, bus.cache_data_in, bus.cache_valid_in} != p_cf))
                viol_stable++;
            if (bus.mem_req && p_mreq && ({bus.mem_wr, bus.mem_addr, bus.mem_wdata} != p_mf))
                viol_stable++;
            if (bus.cache_enable && !p_en && p_ack) viol_reen++;
        end
        p_cf   = {bus.cache_index, bus.cache_word, bus.cache_comp, bus.cache_write,
                  bus.cache_tag_in, bus.cache_data_in, bus.cache_valid_in};
        p_mf   = {bus.mem_wr, bus.mem_addr, bus.mem_wdata};
        p_en   = bus.cache_enable;
        p_mreq = bus.mem_req;
        p_ack  = bus.cache_ack;
    end

    // ---------------- CPU driver ----------------
    task automatic cpu_access(input logic wr, input logic [0:10] addr, input logic [0:15] wd,
                              output logic [0:15] rd, output int lat);
        logic got;
        got = 1'b0;
        rd  = '0;
        lat = 0;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (bus.cpu_done) begin
                rd  = bus.cpu_rdata;
                got = 1'b1;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        check_eq("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic clear_logs();
        mr_q.delete();
        mw_addr_q.delete();
        mw_data_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [0:15] rd;
    int          lat;
    logic        seen;

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cache_hit = 1'b0; bus.cache_dirty = 1'b0; bus.cache_valid = 1'b0;
        bus.cache_tag_out = '0; bus.cache_data_out = '0; bus.mem_rdata = '0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        for (int l = 0; l < 16; l++) begin
            c_valid[l] = 1'b0; c_dirty[l] = 1'b0; c_tag[l] = '0;
            for (int w = 0; w < 4; w++) c_data[l][w] = '0;
        end
        c_valid[5] = 1'b1; c_tag[5] = 5'd3; c_data[5][2] = 16'hBEEF;
        c_valid[9] = 1'b1; c_dirty[9] = 1'b1; c_tag[9] = 5'd4;
        for (int w = 0; w < 4; w++) begin
            c_data[9][w] = 16'hA000 + 16'(w);
            mem[{5'd7, 4'd2, 2'(w)}]  = 16'h1000 + 16'(w);
            mem[{5'd6, 4'd9, 2'(w)}]  = 16'h2000 + 16'(w);
            mem[{5'd1, 4'd12, 2'(w)}] = 16'h3C00 + 16'(w);
        end

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy",   {31'd0, bus.cpu_busy},     32'd0);
        check_eq("rst_done",   {31'd0, bus.cpu_done},     32'd0);
        check_eq("rst_enable", {31'd0, bus.cache_enable}, 32'd0);
        check_eq("rst_memreq", {31'd0, bus.mem_req},      32'd0);
        check_eq("rst_rdata",  {16'd0, bus.cpu_rdata},    32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // read hit, line 5 word 2
        clear_logs();
        cpu_access(1'b0, {5'd3, 4'd5, 2'd2}, 16'h0, rd, lat);
        check_eq("hit_rdata",   {16'd0, rd}, 32'hBEEF);
        check_eq("hit_latency", lat, 4);
        check_eq("hit_no_mem",  mr_q.size() + mw_addr_q.size(), 0);

        // read hit with slower cache ack
        ack_delay = 2;
        cpu_access(1'b0, {5'd3, 4'd5, 2'd2}, 16'h0, rd, lat);
        check_eq("hit_slow_rdata",   {16'd0, rd}, 32'hBEEF);
        check_eq("hit_slow_latency", lat, 6);
        ack_delay = 0;

        // clean read miss, line 2
        clear_logs();
        cpu_access(1'b0, {5'd7, 4'd2, 2'd1}, 16'h0, rd, lat);
        check_eq("clean_rdata",   {16'd0, rd}, 32'h1001);
        check_eq("clean_nreads",  mr_q.size(), 4);
        check_eq("clean_nwrites", mw_addr_q.size(), 0);
        for (int i = 0; i < 4 && i < mr_q.size(); i++)
            check_eq("clean_rd_addr", {21'd0, mr_q[i]}, {21'd0, 5'd7, 4'd2, 2'(i)});
        check_eq("clean_line_tag",   {27'd0, c_tag[2]}, 32'd7);
        check_eq("clean_line_valid", {31'd0, c_valid[2]}, 32'd1);
        check_eq("clean_line_w3",    {16'd0, c_data[2][3]}, 32'h1003);

        // dirty write miss, line 9
        clear_logs();
        cpu_access(1'b1, {5'd6, 4'd9, 2'd3}, 16'h55AA, rd, lat);
        check_eq("dirty_rdata",   {16'd0, rd}, 32'h0);
        check_eq("dirty_nwrites", mw_addr_q.size(), 4);
        check_eq("dirty_nreads",  mr_q.size(), 4);
        for (int i = 0; i < 4 && i < mw_addr_q.size(); i++) begin
            check_eq("wb_addr", {21'd0, mw_addr_q[i]}, {21'd0, 5'd4, 4'd9, 2'(i)});
            check_eq("wb_data", {16'd0, mw_data_q[i]}, 32'hA000 + 32'(i));
        end
        for (int i = 0; i < 4 && i < mr_q.size(); i++)
            check_eq("dirty_fill_addr", {21'd0, mr_q[i]}, {21'd0, 5'd6, 4'd9, 2'(i)});
        check_eq("dirty_line_w3",    {16'd0, c_data[9][3]}, 32'h55AA);
        check_eq("dirty_line_dirty", {31'd0, c_dirty[9]}, 32'd1);
        clear_logs();
        cpu_access(1'b0, {5'd6, 4'd9, 2'd3}, 16'h0, rd, lat);
        check_eq("readback_w3", {16'd0, rd}, 32'h55AA);
        cpu_access(1'b0, {5'd6, 4'd9, 2'd0}, 16'h0, rd, lat);
        check_eq("readback_w0", {16'd0, rd}, 32'h2000);
        check_eq("readback_no_mem", mr_q.size() + mw_addr_q.size(), 0);

        // cache_ack held three extra cycles
        ack_extra = 3;
        cpu_access(1'b0, {5'd3, 4'd5, 2'd2}, 16'h0, rd, lat);
        check_eq("longack_rdata",   {16'd0, rd}, 32'hBEEF);
        check_eq("longack_latency", lat, 7);
        cpu_access(1'b0, {5'd7, 4'd2, 2'd3}, 16'h0, rd, lat);
        check_eq("longack_rdata2",  {16'd0, rd}, 32'h1003);
        ack_extra = 0;

        // reset asserted while waiting in FILL_RD
        mem_ack_en = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = {5'd1, 4'd12, 2'd0};
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_req;
        end
        check_eq("fill_memreq_seen", {31'd0, seen}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("async_memreq", {31'd0, bus.mem_req},  32'd0);
        check_eq("async_busy",   {31'd0, bus.cpu_busy}, 32'd0);
        bus.cpu_req = 1'b0;
        mem_ack_en  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        cpu_access(1'b0, {5'd1, 4'd12, 2'd0}, 16'h0, rd, lat);
        check_eq("post_rst_rdata", {16'd0, rd}, 32'h3C00);

`ifdef CACHE_CTRL_TIMEOUT_EN
        // memory never acks
        mem_ack_en = 1'b0;
        cpu_access(1'b0, {5'd2, 4'd13, 2'd0}, 16'h0, rd, lat);
        check_eq("to_rdata", {16'd0, rd}, 32'h0);
        check_eq("to_err",   {31'd0, bus.err}, 32'd1);
        mem_ack_en = 1'b1;
        cpu_access(1'b0, {5'd3, 4'd5, 2'd2}, 16'h0, rd, lat);
        check_eq("to_next_rdata", {16'd0, rd}, 32'hBEEF);
        check_eq("to_err_sticky", {31'd0, bus.err}, 32'd1);
`else
        check_eq("err_low", {31'd0, bus.err}, 32'd0);
`endif

        check_eq("fields_stable", viol_stable, 0);
        check_eq("no_early_enable", viol_reen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
